// File: rtl/raycast_pixel_gen.sv
// Pixel colouring stage behind the VGA sync generator: double-buffered column store feeding a 3-stage pixel pipeline.
// Optional distance shading of short walls is enabled with `define DIST_SHADE_EN.
module raycast_pixel_gen #(
    parameter int unsigned H_DISPLAY    = 640,
    parameter int unsigned V_DISPLAY    = 480,
    parameter logic [11:0] CEIL_COLOR   = 12'h336,
    parameter logic [11:0] FLOOR_COLOR  = 12'h444,
    parameter logic [11:0] WALL_COLOR_X = 12'hC00,
    parameter logic [11:0] WALL_COLOR_Y = 12'h800
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic [9:0] h_pos,
    input  logic [9:0] v_pos,
    input  logic       h_sync,
    input  logic       v_sync,
    input  logic       col_wr_en,
    input  logic [9:0] col_wr_addr,
    input  logic [8:0] col_wr_height,
    input  logic       col_wr_side,
    input  logic       frame_done,
    output logic       buf_swapped,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs
);

    localparam int unsigned POS_W   = 10;
    localparam int unsigned HEIGHT_W = 9;
    localparam int unsigned ENTRY_W = HEIGHT_W + 1;
    localparam int unsigned RGB_W   = 12;

    localparam logic [POS_W-1:0] H_LIM     = POS_W'(H_DISPLAY);
    localparam logic [POS_W-1:0] V_LIM     = POS_W'(V_DISPLAY);
    localparam logic [POS_W-1:0] V_HALF    = POS_W'(V_DISPLAY / 2);
    localparam logic [POS_W-1:0] V_QUARTER = POS_W'(V_DISPLAY / 4);

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } swap_state_t;

    swap_state_t state;
    logic        front;
    logic        front_valid;

    logic               swap_point_c;
    logic               wr_ok_c;
    logic [POS_W-1:0]   rd_addr_c;

    logic [ENTRY_W-1:0] bank0 [H_DISPLAY];
    logic [ENTRY_W-1:0] bank1 [H_DISPLAY];

    // Stage 1 registers
    logic [ENTRY_W-1:0] s1_entry;
    logic [POS_W-1:0]   s1_v;
    logic               s1_vis;
    logic               s1_fv;
    logic               s1_hs;
    logic               s1_vs;

    // Stage 2 registers
    logic [POS_W-1:0]   s2_top;
    logic [POS_W-1:0]   s2_bot;
    logic [RGB_W-1:0]   s2_wall;
    logic [POS_W-1:0]   s2_v;
    logic               s2_vis;
    logic               s2_fv;
    logic               s2_hs;
    logic               s2_vs;

    logic [POS_W-1:0]   height_c;
    logic [POS_W-1:0]   h_clamp_c;
    logic [POS_W-1:0]   top_c;
    logic [POS_W-1:0]   bot_c;
    logic [RGB_W-1:0]   wall_c;
    logic [RGB_W-1:0]   pixel_c;

    assign swap_point_c = (v_pos == V_LIM) && (h_pos == '0);
    assign wr_ok_c      = col_wr_en && (col_wr_addr < H_LIM);
    assign rd_addr_c    = (h_pos < H_LIM) ? h_pos : '0;

    // Swap request FSM; the swap lands on the first line of vertical blanking
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            front       <= 1'b0;
            front_valid <= 1'b0;
            buf_swapped <= 1'b0;
        end else begin
            buf_swapped <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_done) state <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (swap_point_c) begin
                        front       <= ~front;
                        front_valid <= 1'b1;
                        buf_swapped <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Column banks: writes go to the back bank, reads come from the front bank
    always_ff @(posedge pixel_clk) begin
        if (wr_ok_c && front)  bank0[col_wr_addr] <= {col_wr_side, col_wr_height};
        if (wr_ok_c && !front) bank1[col_wr_addr] <= {col_wr_side, col_wr_height};
        s1_entry <= front ? bank1[rd_addr_c] : bank0[rd_addr_c];
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            s1_v   <= '0;
            s1_vis <= 1'b0;
            s1_fv  <= 1'b0;
            s1_hs  <= 1'b1;
            s1_vs  <= 1'b1;
        end else begin
            s1_v   <= v_pos;
            s1_vis <= (h_pos < H_LIM) && (v_pos < V_LIM);
            s1_fv  <= front_valid;
            s1_hs  <= h_sync;
            s1_vs  <= v_sync;
        end
    end

    // Wall span for the column; height 0 collapses to top == bot at mid-screen
    always_comb begin
        height_c  = POS_W'(s1_entry[HEIGHT_W-1:0]);
        h_clamp_c = (height_c > V_LIM) ? V_LIM : height_c;
        top_c     = (V_LIM - h_clamp_c) >> 1;
        bot_c     = top_c + h_clamp_c;
        wall_c    = s1_entry[ENTRY_W-1] ? WALL_COLOR_Y : WALL_COLOR_X;
`ifdef DIST_SHADE_EN
        if (h_clamp_c < V_QUARTER) wall_c = (wall_c >> 1) & 12'h777;
`endif
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            s2_top  <= '0;
            s2_bot  <= '0;
            s2_wall <= '0;
            s2_v    <= '0;
            s2_vis  <= 1'b0;
            s2_fv   <= 1'b0;
            s2_hs   <= 1'b1;
            s2_vs   <= 1'b1;
        end else begin
            s2_top  <= top_c;
            s2_bot  <= bot_c;
            s2_wall <= wall_c;
            s2_v    <= s1_v;
            s2_vis  <= s1_vis;
            s2_fv   <= s1_fv;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
        end
    end

    always_comb begin
        pixel_c = '0;
        if (s2_vis) begin
            if (!s2_fv)               pixel_c = (s2_v < V_HALF) ? CEIL_COLOR : FLOOR_COLOR;
            else if (s2_v < s2_top)   pixel_c = CEIL_COLOR;
            else if (s2_v < s2_bot)   pixel_c = s2_wall;
            else                      pixel_c = FLOOR_COLOR;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            {vga_r, vga_g, vga_b} <= '0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else begin
            {vga_r, vga_g, vga_b} <= pixel_c;
            vga_hs <= s2_hs;
            vga_vs <= s2_vs;
        end
    end

endmodule

// File: tb/tb_raycast_pixel_gen.sv
// Bench for raycast_pixel_gen: random and directed stimulus against a per-pixel reference model.
module tb_raycast_pixel_gen;

    localparam logic [11:0] CEIL  = 12'h336;
    localparam logic [11:0] FLOOR = 12'h444;
    localparam logic [11:0] WALLX = 12'hC00;
    localparam logic [11:0] WALLY = 12'h800;

    logic       pixel_clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] h_pos = '0, v_pos = '0;
    logic       h_sync = 1'b1, v_sync = 1'b1;
    logic       col_wr_en = 1'b0;
    logic [9:0] col_wr_addr = '0;
    logic [8:0] col_wr_height = '0;
    logic       col_wr_side = 1'b0;
    logic       frame_done = 1'b0;
    logic       buf_swapped;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs;

    always #20 pixel_clk = ~pixel_clk;

    raycast_pixel_gen dut (
        .pixel_clk(pixel_clk), .reset(reset),
        .h_pos(h_pos), .v_pos(v_pos), .h_sync(h_sync), .v_sync(v_sync),
        .col_wr_en(col_wr_en), .col_wr_addr(col_wr_addr),
        .col_wr_height(col_wr_height), .col_wr_side(col_wr_side),
        .frame_done(frame_done), .buf_swapped(buf_swapped),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: two column tables, display selector, pending request
    int m_height [2][640];
    bit m_side   [2][640];
    bit m_front, m_valid, m_pending;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        swp;
    } exp_t;
    exp_t hist [3];

    function automatic logic [11:0] model_rgb(input int h, input int v);
        int hc, top, bot;
        logic [11:0] wc;
        if (h >= 640 || v >= 480) return 12'h000;
        if (!m_valid) return (v < 240) ? CEIL : FLOOR;
        hc  = (m_height[m_front][h] > 480) ? 480 : m_height[m_front][h];
        top = (480 - hc) / 2;
        bot = top + hc;
        if (v < top) return CEIL;
        if (v >= bot) return FLOOR;
        wc = m_side[m_front][h] ? WALLY : WALLX;
`ifdef DIST_SHADE_EN
        if (hc < 120) wc = {wc[11:8] / 4'd2, wc[7:4] / 4'd2, wc[3:0] / 4'd2};
`endif
        return wc;
    endfunction

    // Applies one cycle of inputs, advances the model, waits one clock
    task automatic step(input int h, input int v, input bit we, input int wa,
                        input int wh, input bit ws, input bit fd, input bit rst);
        exp_t e;
        h_pos = 10'(h); v_pos = 10'(v);
        h_sync = 1'($urandom); v_sync = 1'($urandom);
        col_wr_en = we; col_wr_addr = 10'(wa); col_wr_height = 9'(wh); col_wr_side = ws;
        frame_done = fd; reset = rst;
        if (rst) begin
            e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, swp: 1'b0};
            hist[0] = e; hist[1] = e; hist[2] = e;
            m_front = 0; m_valid = 0; m_pending = 0;
        end else begin
            e.rgb = model_rgb(h, v);
            e.hs  = h_sync;
            e.vs  = v_sync;
            e.swp = 1'b0;
            if (we && wa < 640) begin
                m_height[!m_front][wa] = wh;
                m_side[!m_front][wa]   = ws;
            end
            if (m_pending && v == 480 && h == 0) begin
                m_front = !m_front; m_valid = 1; m_pending = 0; e.swp = 1'b1;
            end else if (fd) begin
                m_pending = 1;
            end
        end
        @(posedge pixel_clk); #1;
        if (!rst) begin
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = e;
        end
    endtask

    task automatic idle_step();
        step($urandom_range(799, 1), $urandom_range(520, 0), 0, 0, 0, 0, 0, 0);
    endtask

    // Drives one pixel and flushes it to the outputs
    task automatic probe(input int h, input int v);
        step(h, v, 0, 0, 0, 0, 0, 0);
        idle_step();
        idle_step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step($urandom_range(799, 0), $urandom_range(520, 0), 0, 0, 0, 0, 0, 1);
            checks++;
            if ({vga_r, vga_g, vga_b} !== 12'h000 || vga_hs !== 1'b1 || vga_vs !== 1'b1 || buf_swapped !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: got rgb=%h hs=%b vs=%b swp=%b, expected 000/1/1/0",
                         {vga_r, vga_g, vga_b}, vga_hs, vga_vs, buf_swapped);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(10, 10, 0, 0, 0, 0, 0, 0);
            checks++;
            if ({vga_r, vga_g, vga_b} !== 12'h000 || vga_hs !== 1'b1 || vga_vs !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_blank cyc %0d: got rgb=%h hs=%b vs=%b", i,
                         {vga_r, vga_g, vga_b}, vga_hs, vga_vs);
            end
        end
    endtask

    task automatic test_split_no_writes();
        for (int i = 0; i < 400; i++) begin
            idle_step();
            checks++;
            if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {hist[2].rgb, hist[2].hs, hist[2].vs}) begin
                errors++;
                $display("FAIL split_pixel i=%0d: got %h/%b%b expected %h/%b%b", i,
                         {vga_r, vga_g, vga_b}, vga_hs, vga_vs, hist[2].rgb, hist[2].hs, hist[2].vs);
            end
        end
        probe(320, 239);
        checks++;
        if ({vga_r, vga_g, vga_b} !== CEIL) begin
            errors++; $display("FAIL split_row239: got %h expected %h", {vga_r, vga_g, vga_b}, CEIL);
        end
        probe(320, 240);
        checks++;
        if ({vga_r, vga_g, vga_b} !== FLOOR) begin
            errors++; $display("FAIL split_row240: got %h expected %h", {vga_r, vga_g, vga_b}, FLOOR);
        end
    endtask

    // Fills each bank with random entries so every column has a known value
    task automatic test_fill_banks();
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c < 640; c++) begin
                int hgt = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(511, 0);
                step($urandom_range(799, 1), $urandom_range(520, 0), 1, c, hgt, 1'($urandom), 0, 0);
                checks++;
                if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {hist[2].rgb, hist[2].hs, hist[2].vs}) begin
                    errors++;
                    $display("FAIL fill_pixel c=%0d: got %h expected %h", c, {vga_r, vga_g, vga_b}, hist[2].rgb);
                end
            end
            step(100, 100, 0, 0, 0, 0, 1, 0);
            idle_step();
            step(0, 480, 0, 0, 0, 0, 0, 0);
            checks++;
            if (buf_swapped !== 1'b1) begin
                errors++; $display("FAIL fill_swap pass=%0d: got buf_swapped=%b expected 1", pass, buf_swapped);
            end
            step(1, 480, 0, 0, 0, 0, 0, 0);
            checks++;
            if (buf_swapped !== 1'b0) begin
                errors++; $display("FAIL fill_swap_pulse pass=%0d: got buf_swapped=%b expected 0", pass, buf_swapped);
            end
        end
        for (int i = 0; i < 1500; i++) begin
            idle_step();
            checks++;
            if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {hist[2].rgb, hist[2].hs, hist[2].vs}) begin
                errors++;
                $display("FAIL walls_pixel i=%0d: got %h/%b%b expected %h/%b%b", i,
                         {vga_r, vga_g, vga_b}, vga_hs, vga_vs, hist[2].rgb, hist[2].hs, hist[2].vs);
            end
        end
    endtask

    task automatic test_column_100();
        int          rows [6] = '{0, 139, 140, 339, 340, 479};
        logic [11:0] exps [6] = '{CEIL, CEIL, WALLX, WALLX, FLOOR, FLOOR};
        step(300, 30, 1, 100, 200, 0, 0, 0);
        step(300, 31, 0, 0, 0, 0, 1, 0);
        step(0, 480, 0, 0, 0, 0, 0, 0);
        checks++;
        if (buf_swapped !== 1'b1) begin
            errors++; $display("FAIL col100_swap: got buf_swapped=%b expected 1", buf_swapped);
        end
        for (int i = 0; i < 6; i++) begin
            probe(100, rows[i]);
            checks++;
            if ({vga_r, vga_g, vga_b} !== exps[i]) begin
                errors++;
                $display("FAIL col100_row%0d: got %h expected %h", rows[i], {vga_r, vga_g, vga_b}, exps[i]);
            end
        end
    endtask

    task automatic test_clamp_and_bad_addr();
        step(300, 30, 1, 5, 511, 1, 0, 0);
        step(300, 31, 1, 700, 50, 0, 0, 0);
        step(300, 32, 0, 0, 0, 0, 1, 0);
        step(0, 480, 0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 482; r++) begin
            step(5, (r < 480) ? r : 500, 0, 0, 0, 0, 0, 0);
            if (r >= 2) begin
                checks++;
                if ({vga_r, vga_g, vga_b} !== WALLY) begin
                    errors++;
                    $display("FAIL clamp_row%0d: got %h expected %h", r - 2, {vga_r, vga_g, vga_b}, WALLY);
                end
            end
        end
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(639, 0), $urandom_range(479, 0), 0, 0, 0, 0, 0, 0);
            checks++;
            if ({vga_r, vga_g, vga_b} !== hist[2].rgb) begin
                errors++;
                $display("FAIL after_bad_addr i=%0d: got %h expected %h", i, {vga_r, vga_g, vga_b}, hist[2].rgb);
            end
        end
    endtask

    task automatic test_swap_cycle_write();
        int pulses = 0;
        step(300, 200, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(301 + i, 200, 0, 0, 0, 0, 1, 0);
        step(0, 480, 1, 0, 300, 0, 0, 0);
        checks++;
        if (buf_swapped !== 1'b1) begin
            errors++; $display("FAIL swapcyc_swap: got buf_swapped=%b expected 1", buf_swapped);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 3) step(0, 480, 0, 0, 0, 0, 0, 0);
            else idle_step();
            pulses += int'(buf_swapped);
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL swapcyc_single_pulse: got %0d extra pulses expected 0", pulses);
        end
        probe(0, 240);
        checks++;
        if ({vga_r, vga_g, vga_b} !== WALLX) begin
            errors++; $display("FAIL swapcyc_col0_wall: got %h expected %h", {vga_r, vga_g, vga_b}, WALLX);
        end
        probe(0, 50);
        checks++;
        if ({vga_r, vga_g, vga_b} !== CEIL) begin
            errors++; $display("FAIL swapcyc_col0_ceil: got %h expected %h", {vga_r, vga_g, vga_b}, CEIL);
        end
        step(0, 480, 0, 0, 0, 0, 1, 0);
        checks++;
        if (buf_swapped !== 1'b0) begin
            errors++; $display("FAIL idle_fd_at_swap_point: got buf_swapped=%b expected 0", buf_swapped);
        end
        idle_step();
        step(0, 480, 0, 0, 0, 0, 0, 0);
        checks++;
        if (buf_swapped !== 1'b1) begin
            errors++; $display("FAIL next_frame_swap: got buf_swapped=%b expected 1", buf_swapped);
        end
    endtask

    task automatic test_shade();
        step(300, 30, 1, 10, 100, 0, 0, 0);
        step(300, 31, 1, 11, 120, 0, 0, 0);
        step(300, 32, 0, 0, 0, 0, 1, 0);
        step(0, 480, 0, 0, 0, 0, 0, 0);
        probe(10, 240);
        checks++;
`ifdef DIST_SHADE_EN
        if ({vga_r, vga_g, vga_b} !== 12'h600) begin
            errors++; $display("FAIL shade_h100: got %h expected 600", {vga_r, vga_g, vga_b});
        end
`else
        if ({vga_r, vga_g, vga_b} !== WALLX) begin
            errors++; $display("FAIL noshade_h100: got %h expected %h", {vga_r, vga_g, vga_b}, WALLX);
        end
`endif
        probe(11, 240);
        checks++;
        if ({vga_r, vga_g, vga_b} !== WALLX) begin
            errors++; $display("FAIL shade_h120: got %h expected %h", {vga_r, vga_g, vga_b}, WALLX);
        end
    endtask

    task automatic test_reset_pending();
        step(300, 100, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) idle_step();
        step(0, 480, 0, 0, 0, 0, 0, 0);
        checks++;
        if (buf_swapped !== 1'b0) begin
            errors++; $display("FAIL reset_drops_pending: got buf_swapped=%b expected 0", buf_swapped);
        end
        probe(100, 150);
        checks++;
        if ({vga_r, vga_g, vga_b} !== CEIL) begin
            errors++; $display("FAIL reset_split_ceil: got %h expected %h", {vga_r, vga_g, vga_b}, CEIL);
        end
        probe(100, 300);
        checks++;
        if ({vga_r, vga_g, vga_b} !== FLOOR) begin
            errors++; $display("FAIL reset_split_floor: got %h expected %h", {vga_r, vga_g, vga_b}, FLOOR);
        end
    endtask

    task automatic test_random_mix();
        for (int i = 0; i < 4000; i++) begin
            int  h  = $urandom_range(799, 0);
            int  v  = $urandom_range(520, 0);
            bit  we = ($urandom_range(9, 0) == 0);
            bit  fd = ($urandom_range(99, 0) == 0);
            if ($urandom_range(49, 0) == 0) begin h = 0; v = 480; end
            step(h, v, we, $urandom_range(767, 0), $urandom_range(511, 0), 1'($urandom), fd, 0);
            checks++;
            if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {hist[2].rgb, hist[2].hs, hist[2].vs}) begin
                errors++;
                $display("FAIL mix_pixel i=%0d: got %h/%b%b expected %h/%b%b", i,
                         {vga_r, vga_g, vga_b}, vga_hs, vga_vs, hist[2].rgb, hist[2].hs, hist[2].vs);
            end
            checks++;
            if (buf_swapped !== hist[0].swp) begin
                errors++;
                $display("FAIL mix_swap i=%0d: got buf_swapped=%b expected %b", i, buf_swapped, hist[0].swp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_split_no_writes();
        test_fill_banks();
        test_column_100();
        test_clamp_and_bad_addr();
        test_swap_cycle_write();
        test_shade();
        test_reset_pending();
        test_fill_banks();
        test_random_mix();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
